im_fetch: RTL

//  Instruction-fetch initiator for the word-addressed, read-only instruction memory (im).

---
 rtl/im_fetch_if.sv | 28 ++
 rtl/im_fetch.sv | 124 ++++++++++++
 2 files changed

// File: rtl/im_fetch_if.sv
// Fetch-side bus: instruction memory read port, control inputs and decode handshake.
//  im_addr     fetch PC to the instruction memory read_addr
//  im_data     word returned by the instruction memory for im_addr
//  halt        level, suppresses new fetches
//  br_taken    one-cycle redirect strobe, br_addr is the target word address
//  instr       FIFO head word, instr_pc the address it came from
//  instr_valid FIFO head valid, instr_ready decode accepts the head
interface im_fetch_if;
  logic [15:0] im_addr;
  logic [31:0] im_data;
  logic        halt;
  logic        br_taken;
  logic [15:0] br_addr;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output im_addr, instr, instr_pc, instr_valid,
    input  im_data, halt, br_taken, br_addr, instr_ready
  );

  modport slave (
    input  im_addr, instr, instr_pc, instr_valid,
    output im_data, halt, br_taken, br_addr, instr_ready
  );
endinterface

// File: rtl/im_fetch.sv
// Instruction-fetch initiator: holds the fetch PC, reads the combinational
// instruction memory and queues {word, address} pairs for decode.
// Ports: clk, rst_f (async active-low), bus (im_fetch_if.master) carrying the
// memory read port, halt/redirect controls and the decode valid/ready handshake.
module im_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic       clk,
  input  logic       rst_f,
  im_fetch_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [15:0]   pc;
  logic [31:0]   fifo_data [DEPTH];
  logic [15:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          pop_c;
  logic          push_c;
  logic          fetching_c;

  assign pop_c      = (count != '0) & bus.instr_ready;
  assign fetching_c = (state == S_FETCH) | (state == S_FULL);
  assign push_c     = fetching_c & ~bus.halt & ~bus.br_taken &
                      ((count < CW'(DEPTH)) | pop_c);

  // Outputs come straight from registers; head is never moved onto a stale slot
  assign bus.im_addr     = pc;
  assign bus.instr       = fifo_data[head];
  assign bus.instr_pc    = fifo_pc[head];
  assign bus.instr_valid = (count != '0);

  // Occupancy after this edge; a redirect wins over any push/pop
  always_comb begin
    count_nx = count;
    if (bus.br_taken)
      count_nx = '0;
    else if (push_c && !pop_c)
      count_nx = count + CW'(1);
    else if (pop_c && !push_c)
      count_nx = count - CW'(1);
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH, S_FULL: begin
        if (bus.halt)
          state_nx = S_HALT;
        else if (count_nx == CW'(DEPTH))
          state_nx = S_FULL;
        else
          state_nx = S_FETCH;
      end
      S_HALT: begin
        if (bus.halt)
          state_nx = S_HALT;
        else if (count_nx == CW'(DEPTH))
          state_nx = S_FULL;
        else
          state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  // PC, FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      count <= count_nx;
      if (bus.br_taken) begin
        // Flush by pulling tail back to head so instr keeps the last head value
        pc   <= bus.br_addr;
        tail <= head;
      end else begin
        if (push_c) begin
          fifo_data[tail] <= bus.im_data;
          fifo_pc[tail]   <= pc;
          pc              <= pc + 16'd1;
        end
        if (pop_c && !push_c && (count == CW'(1))) begin
          // Emptying: leave head parked on the last delivered entry
          tail <= head;
        end else begin
          if (push_c) tail <= tail + AW'(1);
          if (pop_c)  head <= head + AW'(1);
        end
      end
    end
  end

endmodule
